// File: rtl/datapath_sequencer.sv
// ---------------------------------------------------------------------------
// datapath_sequencer
//
// Multi-cycle control sequencer for the MIPS-style datapath. It accepts one
// 16-bit instruction per valid/ready handshake and steps it through
// READ -> EXEC -> (MEM) -> (WB), driving the datapath control interface.
// It also captures ALU status flags and counts retired instructions.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   instr, instr_valid  instruction word and its valid strobe
//   instr_ready         high only in IDLE; the handshake accepts instr
//   alu_zero, alu_ovf   live ALU status, captured at the end of EXEC
//   RegWrite, RegRead   register file write strobe / read enable
//   rd0_addr, rd1_addr  source register addresses (rs, rt)
//   wr_addr             destination register address
//   ALUSrc1, ALUSrc2    operand selects (constant zero for A, imm for B)
//   ALUOp, imm          ALU operation and immediate operand
//   MemWrite, MemtoReg  data memory write strobe / write-back source select
//   done, err           retire pulse; err accompanies done for bad opcodes
//   zero_flag, ovf_flag flags from the last ALU-class instruction
//   instr_count         retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module datapath_sequencer #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             RegWrite,
  output logic             RegRead,
  output logic [1:0]       rd0_addr,
  output logic [1:0]       rd1_addr,
  output logic [1:0]       wr_addr,
  output logic             ALUSrc1,
  output logic             ALUSrc2,
  output logic [2:0]       ALUOp,
  output logic [7:0]       imm,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             done,
  output logic             err,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_RALU = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LI   = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] op_q;

  // Fields of the word currently offered on instr.
  logic [3:0] in_op;
  logic [1:0] in_rs;
  logic [1:0] in_rt;
  logic [1:0] in_rd;
  logic [2:0] in_funct;
  logic       in_itype;

  assign in_op    = instr[15:12];
  assign in_rs    = instr[11:10];
  assign in_rt    = instr[9:8];
  assign in_rd    = instr[7:6];
  assign in_funct = instr[2:0];
  // ADDI, LI, LW and SW all take imm as ALU operand B.
  assign in_itype = (in_op >= OP_ADDI) && (in_op <= OP_SW);

  logic accept;
  logic op_illegal;
  logic op_alu;

  assign accept     = (state == S_IDLE) && instr_valid;
  assign op_illegal = (op_q > OP_SW);
  assign op_alu     = (op_q == OP_RALU) || (op_q == OP_ADDI) || (op_q == OP_LI);

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_READ;
      S_READ: begin
        if (op_q == OP_NOP || op_illegal) state_nxt = S_IDLE;
        else                              state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_LW || op_q == OP_SW) state_nxt = S_MEM;
        else                                state_nxt = S_WB;
      end
      S_MEM: begin
        if (op_q == OP_LW) state_nxt = S_WB;
        else               state_nxt = S_IDLE;
      end
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, latched instruction fields, flags and counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every control register has a reset value so nothing leaves reset as X.
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      rd0_addr    <= '0;
      rd1_addr    <= '0;
      wr_addr     <= '0;
      ALUSrc1     <= 1'b0;
      ALUSrc2     <= 1'b0;
      ALUOp       <= '0;
      imm         <= '0;
      zero_flag   <= 1'b0;
      ovf_flag    <= 1'b0;
      instr_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;

      // Operand fields are captured once and held through retire and beyond.
      if (accept) begin
        op_q     <= in_op;
        rd0_addr <= in_rs;
        rd1_addr <= in_rt;
        wr_addr  <= (in_op == OP_RALU) ? in_rd : in_rt;
        ALUSrc1  <= (in_op == OP_LI);
        ALUSrc2  <= in_itype;
        ALUOp    <= (in_op == OP_RALU) ? in_funct : ALU_ADD;
        imm      <= in_itype ? instr[7:0] : 8'h00;
      end

      // The ALU has settled by the last EXEC cycle; loads/stores leave flags alone.
      if (state == S_EXEC && op_alu) begin
        zero_flag <= alu_zero;
        ovf_flag  <= alu_ovf;
      end

      if (done) instr_count <= instr_count + 1'b1;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them
  // without waiting for a clock edge.
  assign instr_ready = (state == S_IDLE);
  assign RegRead     = (state == S_READ);
  assign RegWrite    = (state == S_WB);
  assign MemWrite    = (state == S_MEM) && (op_q == OP_SW);
  // LW keeps MemtoReg through WB to cover the synchronous memory read latency.
  assign MemtoReg    = ((state == S_MEM) || (state == S_WB)) && (op_q == OP_LW);
  assign err         = (state == S_READ) && op_illegal;
  assign done        = ((state == S_READ) && ((op_q == OP_NOP) || op_illegal)) ||
                       ((state == S_MEM)  && (op_q == OP_SW)) ||
                       (state == S_WB);

endmodule

// File: tb/tb_datapath_sequencer.sv
// ---------------------------------------------------------------------------
// tb_datapath_sequencer
//
// Directed testbench for datapath_sequencer: a table of instructions with
// hand-computed latency, strobe activity, latched fields and flags, plus
// hand-written sequences for reset during LW and counter wrap.
// ---------------------------------------------------------------------------
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_zero;
  logic        alu_ovf;
  logic        RegWrite;
  logic        RegRead;
  logic [1:0]  rd0_addr;
  logic [1:0]  rd1_addr;
  logic [1:0]  wr_addr;
  logic        ALUSrc1;
  logic        ALUSrc2;
  logic [2:0]  ALUOp;
  logic [7:0]  imm;
  logic        MemWrite;
  logic        MemtoReg;
  logic        done;
  logic        err;
  logic        zero_flag;
  logic        ovf_flag;
  logic [7:0]  instr_count;

  always #5 clk = ~clk;

  datapath_sequencer #(.ALU_ADD(3'b000), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .RegWrite(RegWrite), .RegRead(RegRead),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .wr_addr(wr_addr),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOp(ALUOp), .imm(imm),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .done(done), .err(err),
    .zero_flag(zero_flag), .ovf_flag(ovf_flag), .instr_count(instr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic        z;
    logic        o;
    int          lat;
    int          rw;
    int          mw;
    int          m2r;
    int          er;
    logic [1:0]  rd0;
    logic [1:0]  rd1;
    logic [1:0]  wr;
    logic [2:0]  aop;
    logic        s1;
    logic        s2;
    logic [7:0]  immv;
    logic        zf;
    logic        of;
  } vec_t;

  // Results of one instruction as observed cycle by cycle.
  int   r_lat, r_rw, r_mw, r_m2r, r_er;
  logic r_rr1, r_busy_bad;

  // Offers ins, holds instr_valid high until done, and returns at the
  // falling edge of the done cycle. Cycle 1 is the cycle after the accept edge.
  task automatic run_instr(input logic [15:0] ins, input logic z, input logic o);
    int  w;
    bit  got;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    instr       = ins;
    instr_valid = 1'b1;
    alu_zero    = z;
    alu_ovf     = o;
    r_lat = 0; r_rw = 0; r_mw = 0; r_m2r = 0; r_er = 0;
    r_rr1 = 1'b0; r_busy_bad = 1'b0;
    got = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (c == 1) r_rr1 = RegRead;
      if (RegWrite) r_rw++;
      if (MemWrite) r_mw++;
      if (MemtoReg) r_m2r++;
      if (err)      r_er++;
      if (instr_ready) r_busy_bad = 1'b1;
      if (done) begin
        got   = 1'b1;
        r_lat = c;
      end
    end
  endtask

  vec_t vecs[9];
  int   exp_count;

  initial begin
    // ins    z  o  lat rw mw m2r er rd0 rd1 wr aop    s1 s2 imm    zf of
    vecs[0] = '{16'h3105, 0, 0, 3, 1, 0, 0, 0, 0, 1, 1, 3'b000, 1, 1, 8'h05, 0, 0}; // LI r1,5
    vecs[1] = '{16'h16C1, 0, 1, 3, 1, 0, 0, 0, 1, 2, 3, 3'b001, 0, 0, 8'h00, 0, 1}; // RALU ovf
    vecs[2] = '{16'h5110, 1, 0, 3, 0, 1, 0, 0, 0, 1, 1, 3'b000, 0, 1, 8'h10, 0, 1}; // SW
    vecs[3] = '{16'h4210, 1, 0, 4, 1, 0, 2, 0, 0, 2, 2, 3'b000, 0, 1, 8'h10, 0, 1}; // LW
    vecs[4] = '{16'h2A7F, 1, 0, 3, 1, 0, 0, 0, 2, 2, 2, 3'b000, 0, 1, 8'h7F, 1, 0}; // ADDI zero
    vecs[5] = '{16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 8'h00, 1, 0}; // NOP
    vecs[6] = '{16'hF123, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 3'b000, 0, 0, 8'h00, 1, 0}; // illegal
    vecs[7] = '{16'h2405, 0, 1, 3, 1, 0, 0, 0, 1, 0, 0, 3'b000, 0, 1, 8'h05, 0, 1}; // ADDI ovf
    vecs[8] = '{16'h1C46, 1, 1, 3, 1, 0, 0, 0, 3, 0, 1, 3'b110, 0, 0, 8'h00, 1, 1}; // RALU f=6

    rst = 1'b1; instr = '0; instr_valid = 1'b0; alu_zero = 1'b0; alu_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_ready",  instr_ready, 1);
    check("rst_strobe", {RegWrite, RegRead, MemWrite, MemtoReg, done, err}, 0);
    check("rst_fields", {rd0_addr, rd1_addr, wr_addr, ALUSrc1, ALUSrc2, ALUOp, imm}, 0);
    check("rst_flags",  {zero_flag, ovf_flag}, 0);
    check("rst_count",  instr_count, 0);

    // Reset in the MEM cycle of an LW: strobes drop with no clock edge.
    instr = 16'h4210; instr_valid = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("lwrst_mem_m2r", MemtoReg, 1);
    check("lwrst_mem_rw",  RegWrite, 0);
    #2 rst = 1'b1;
    #1;
    check("lwrst_strobes", {RegWrite, MemtoReg, MemWrite, done}, 0);
    check("lwrst_ready",   instr_ready, 1);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("lwrst_count", instr_count, 0);
    check("lwrst_idle",  {instr_ready, RegRead}, 2'b10);

    // Table-driven instructions, issued back to back.
    exp_count = 0;
    for (int i = 0; i < 9; i++) begin
      run_instr(vecs[i].ins, vecs[i].z, vecs[i].o);
      check($sformatf("v%0d_latency", i),  r_lat, vecs[i].lat);
      check($sformatf("v%0d_regwrite", i), r_rw,  vecs[i].rw);
      check($sformatf("v%0d_memwrite", i), r_mw,  vecs[i].mw);
      check($sformatf("v%0d_memtoreg", i), r_m2r, vecs[i].m2r);
      check($sformatf("v%0d_err", i),      r_er,  vecs[i].er);
      check($sformatf("v%0d_regread", i),  r_rr1, 1);
      check($sformatf("v%0d_busy_ready", i), r_busy_bad, 0);
      check($sformatf("v%0d_addrs", i), {rd0_addr, rd1_addr, wr_addr},
            {vecs[i].rd0, vecs[i].rd1, vecs[i].wr});
      check($sformatf("v%0d_alu", i), {ALUSrc1, ALUSrc2, ALUOp},
            {vecs[i].s1, vecs[i].s2, vecs[i].aop});
      check($sformatf("v%0d_imm", i), imm, vecs[i].immv);
      check($sformatf("v%0d_flags", i), {zero_flag, ovf_flag}, {vecs[i].zf, vecs[i].of});
      exp_count++;
      instr_valid = 1'b0;
      alu_zero = 1'b0; alu_ovf = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ready_back", i), instr_ready, 1);
      check($sformatf("v%0d_count", i), instr_count, exp_count);
      check($sformatf("v%0d_fields_hold", i), {rd0_addr, rd1_addr, wr_addr, imm},
            {vecs[i].rd0, vecs[i].rd1, vecs[i].wr, vecs[i].immv});
    end

    // 256 NOPs from reset: counter wraps back to 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      run_instr(16'h0000, 1'b0, 1'b0);
      instr_valid = 1'b0;
      @(negedge clk);
      if (i == 254) check("wrap_255", instr_count, 255);
    end
    check("wrap_zero", instr_count, 0);
    check("wrap_flags", {zero_flag, ovf_flag}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
